decode_module: RTL and testbench

- Instruction-decode / operand-fetch stage of the RISC pipeline; the producing end of the execute-stage input interface.
- Decodes the 32-bit IR, reads a 32x32 register file, and registers control plus operands toward execute_module.
- Accepts the write-back from the last stage into the register file.
- Detects the one-cycle RAW hazard against the instruction in EX, stalls upstream and injects a bubble.

---
 rtl/decode_module.sv | 168 ++++++++++++++++
 tb/tb_decode_module.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/decode_module.sv
// Decode / operand-fetch stage: decodes IR_1, reads the 32-entry register file with
// write-back bypass, detects the one-cycle RAW hazard against EX and registers controls.
module decode_module #(
    parameter int REG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [31:0]      IR_1,
    input  logic [15:0]      PC_1,
    input  logic             FLUSH,
    input  logic             RW_3,
    input  logic [4:0]       DA_3,
    input  logic [REG_W-1:0] BUS_D,
    output logic [15:0]      PC_2,
    output logic [REG_W-1:0] A,
    output logic [REG_W-1:0] B,
    output logic [4:0]       FS,
    output logic [4:0]       SH,
    output logic             MW,
    output logic             PS,
    output logic [1:0]       BS,
    output logic             RW,
    output logic [4:0]       DA,
    output logic [1:0]       MD,
    output logic             STALL,
    output logic [CNT_W-1:0] STALL_CNT
);

    localparam logic [6:0] OP_ADD = 7'h02;
    localparam logic [6:0] OP_AND = 7'h08;
    localparam logic [6:0] OP_SRL = 7'h12;
    localparam logic [6:0] OP_ADI = 7'h22;
    localparam logic [6:0] OP_LD  = 7'h21;
    localparam logic [6:0] OP_ST  = 7'h03;
    localparam logic [6:0] OP_BZ  = 7'h20;
    localparam logic [6:0] OP_BNZ = 7'h24;
    localparam logic [6:0] OP_JMP = 7'h30;

    logic [REG_W-1:0] rf_q [0:31];

    logic [15:0]      pc2_q, pc2_d;
    logic [REG_W-1:0] a_q, a_d, b_q, b_d;
    logic [4:0]       fs_q, fs_d, sh_q, sh_d, da_q, da_d;
    logic             mw_q, mw_d, ps_q, ps_d, rw_q, rw_d;
    logic [1:0]       bs_q, bs_d, md_q, md_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [6:0]       opc;
    logic [4:0]       dr, sa, sb;
    logic [REG_W-1:0] ra, rb, im_z, im_s;
    logic             valid, uses_sa, uses_sb, hazard;

    assign opc  = IR_1[31:25];
    assign dr   = IR_1[24:20];
    assign sa   = IR_1[19:15];
    assign sb   = IR_1[14:10];
    assign im_z = {{(REG_W-15){1'b0}}, IR_1[14:0]};
    assign im_s = {{(REG_W-15){IR_1[14]}}, IR_1[14:0]};

    // Write-back data is forwarded so a same-cycle write is visible to the read.
    always_comb begin
        ra = '0;
        rb = '0;
        if (sa != 5'd0) ra = (RW_3 && DA_3 == sa) ? BUS_D : rf_q[sa];
        if (sb != 5'd0) rb = (RW_3 && DA_3 == sb) ? BUS_D : rf_q[sb];
    end

    always_comb begin
        valid = 1'b1;
        a_d   = ra;
        b_d   = '0;
        fs_d  = '0;
        sh_d  = '0;
        mw_d  = 1'b0;
        ps_d  = 1'b0;
        bs_d  = 2'b00;
        rw_d  = 1'b0;
        md_d  = 2'b00;
        case (opc)
            OP_ADD: begin fs_d = 5'b00010; b_d = rb; rw_d = 1'b1; end
            OP_AND: begin fs_d = 5'b01000; b_d = rb; rw_d = 1'b1; end
            OP_SRL: begin fs_d = 5'b10010; sh_d = IR_1[4:0]; rw_d = 1'b1; end
            OP_ADI: begin fs_d = 5'b00010; b_d = im_z; rw_d = 1'b1; end
            OP_LD:  begin md_d = 2'b01; rw_d = 1'b1; end
            OP_ST:  begin mw_d = 1'b1; b_d = rb; end
            OP_BZ:  begin bs_d = 2'b01; b_d = im_s; end
            OP_BNZ: begin bs_d = 2'b01; ps_d = 1'b1; b_d = im_s; end
            OP_JMP: begin bs_d = 2'b10; b_d = im_s; a_d = '0; end
            default: begin valid = 1'b0; a_d = '0; end
        endcase
        da_d    = rw_d ? dr : 5'd0;
        uses_sa = valid && (opc != OP_JMP);
        uses_sb = (opc == OP_ADD) || (opc == OP_AND) || (opc == OP_ST);
        hazard  = rw_q && ((uses_sa && sa != 5'd0 && sa == da_q) ||
                           (uses_sb && sb != 5'd0 && sb == da_q));
        STALL   = hazard && !FLUSH;
        pc2_d   = valid ? PC_1 : pc2_q;
        cnt_d   = (STALL && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;

        // Flush or hazard turns this slot into a bubble with PC_2 held.
        if (FLUSH || hazard) begin
            pc2_d = pc2_q;
            a_d   = '0;
            b_d   = '0;
            fs_d  = '0;
            sh_d  = '0;
            mw_d  = 1'b0;
            ps_d  = 1'b0;
            bs_d  = 2'b00;
            rw_d  = 1'b0;
            da_d  = '0;
            md_d  = 2'b00;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            pc2_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            fs_q  <= '0;
            sh_q  <= '0;
            mw_q  <= 1'b0;
            ps_q  <= 1'b0;
            bs_q  <= '0;
            rw_q  <= 1'b0;
            da_q  <= '0;
            md_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc2_q <= pc2_d;
            a_q   <= a_d;
            b_q   <= b_d;
            fs_q  <= fs_d;
            sh_q  <= sh_d;
            mw_q  <= mw_d;
            ps_q  <= ps_d;
            bs_q  <= bs_d;
            rw_q  <= rw_d;
            da_q  <= da_d;
            md_q  <= md_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (RW_3 && DA_3 != 5'd0) begin
            rf_q[DA_3] <= BUS_D;
        end
    end

    assign PC_2      = pc2_q;
    assign A         = a_q;
    assign B         = b_q;
    assign FS        = fs_q;
    assign SH        = sh_q;
    assign MW        = mw_q;
    assign PS        = ps_q;
    assign BS        = bs_q;
    assign RW        = rw_q;
    assign DA        = da_q;
    assign MD        = md_q;
    assign STALL_CNT = cnt_q;

endmodule

// File: tb/tb_decode_module.sv
// Directed-vector bench for decode_module: the driver queues hand-computed expectations,
// a monitor pops and compares them against the registered outputs after each edge.
module tb_decode_module;

    typedef struct packed {
        logic [15:0] pc2;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  fs;
        logic [4:0]  sh;
        logic        mw;
        logic        ps;
        logic [1:0]  bs;
        logic        rw;
        logic [4:0]  da;
        logic [1:0]  md;
        logic        st;
        logic [15:0] cnt;
    } exp_t;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] IR_1 = '0;
    logic [15:0] PC_1 = '0;
    logic        FLUSH = 1'b0;
    logic        RW_3 = 1'b0;
    logic [4:0]  DA_3 = '0;
    logic [31:0] BUS_D = '0;
    logic [15:0] PC_2;
    logic [31:0] A, B;
    logic [4:0]  FS, SH, DA;
    logic        MW, PS, RW, STALL;
    logic [1:0]  BS, MD;
    logic [15:0] STALL_CNT;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    decode_module #(.REG_W(32), .CNT_W(16)) dut (
        .CLK(CLK), .reset(reset), .IR_1(IR_1), .PC_1(PC_1), .FLUSH(FLUSH),
        .RW_3(RW_3), .DA_3(DA_3), .BUS_D(BUS_D), .PC_2(PC_2), .A(A), .B(B),
        .FS(FS), .SH(SH), .MW(MW), .PS(PS), .BS(BS), .RW(RW), .DA(DA), .MD(MD),
        .STALL(STALL), .STALL_CNT(STALL_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] enc_r(logic [6:0] op, logic [4:0] dr, logic [4:0] sa,
                                          logic [4:0] sb, logic [4:0] sh);
        return {op, dr, sa, sb, 5'd0, sh};
    endfunction

    function automatic logic [31:0] enc_i(logic [6:0] op, logic [4:0] dr, logic [4:0] sa,
                                          logic [14:0] im);
        return {op, dr, sa, im};
    endfunction

    function automatic exp_t mk(logic [15:0] pc2, logic [31:0] a, logic [31:0] b,
                                logic [4:0] fs, logic [4:0] sh, logic mw, logic ps,
                                logic [1:0] bs, logic rw, logic [4:0] da, logic [1:0] md,
                                logic st, logic [15:0] cnt);
        exp_t e;
        e = '{pc2, a, b, fs, sh, mw, ps, bs, rw, da, md, st, cnt};
        return e;
    endfunction

    function automatic exp_t bub(logic [15:0] pc2, logic st, logic [15:0] cnt);
        return mk(pc2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st, cnt);
    endfunction

    function automatic exp_t dut_now(logic st);
        return mk(PC_2, A, B, FS, SH, MW, PS, BS, RW, DA, MD, st, STALL_CNT);
    endfunction

    task automatic check(string nm, exp_t got, exp_t want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, got, want);
        end
    endtask

    task automatic step(logic rst, logic [31:0] ir, logic [15:0] pc, logic fl,
                        logic rw3, logic [4:0] da3, logic [31:0] bd, exp_t e);
        @(negedge CLK);
        reset = rst;
        IR_1  = ir;
        PC_1  = pc;
        FLUSH = fl;
        RW_3  = rw3;
        DA_3  = da3;
        BUS_D = bd;
        q.push_back(e);
    endtask

    // STALL is combinational on the current inputs, so it is sampled mid-cycle.
    initial begin
        int   k;
        logic st_s;
        exp_t e;
        k = 0;
        forever begin
            @(negedge CLK);
            #2 st_s = STALL;
            @(posedge CLK);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                k++;
                check($sformatf("step%0d", k), dut_now(st_s), e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge CLK);
        #2 check("reset_state", dut_now(STALL), bub(0, 0, 0));

        // 1-3: ADI R1=5, ADI R2=19 with write-backs, then a NOP
        step(1, 32'h4410_0005, 0, 0, 0, 0, 0, mk(0, 0, 5, 2, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        step(1, enc_i(7'h22, 2, 0, 19), 1, 0, 1, 1, 5, mk(1, 0, 19, 2, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        step(1, 0, 2, 0, 1, 2, 19, bub(1, 0, 0));
        // 4-6: ADD R3,R1,R2; ADD R4,R3,R1 stalls once, then issues with R3 bypassed
        step(1, enc_r(7'h02, 3, 1, 2, 0), 3, 0, 0, 0, 0, mk(3, 5, 19, 2, 0, 0, 0, 0, 1, 3, 0, 0, 0));
        step(1, enc_r(7'h02, 4, 3, 1, 0), 4, 0, 0, 0, 0, bub(3, 1, 1));
        step(1, enc_r(7'h02, 4, 3, 1, 0), 4, 0, 1, 3, 24, mk(4, 24, 5, 2, 0, 0, 0, 0, 1, 4, 0, 0, 1));
        // 7-8: SRL with same-cycle write of R7, then R7 read from the file
        step(1, enc_r(7'h12, 8, 7, 0, 4), 5, 0, 1, 7, 32'hFFFA,
             mk(5, 32'hFFFA, 0, 5'b10010, 4, 0, 0, 0, 1, 8, 0, 0, 1));
        step(1, enc_r(7'h02, 9, 7, 0, 0), 6, 0, 0, 0, 0, mk(6, 32'hFFFA, 0, 2, 0, 0, 0, 0, 1, 9, 0, 0, 1));
        // 9-10: FLUSH over a hazard; writes to R0 are ignored and not bypassed
        step(1, enc_r(7'h02, 10, 9, 1, 0), 7, 1, 1, 0, 32'h1234, bub(6, 0, 1));
        step(1, enc_r(7'h02, 11, 0, 1, 0), 8, 0, 1, 0, 32'h1234, mk(8, 0, 5, 2, 0, 0, 0, 0, 1, 11, 0, 0, 1));
        // 11-12: ST hazard on SA, then ST issues
        step(1, enc_r(7'h03, 0, 11, 1, 0), 9, 0, 0, 0, 0, bub(8, 1, 2));
        step(1, enc_r(7'h03, 0, 11, 1, 0), 9, 0, 0, 0, 0, mk(9, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2));
        // 13-18: LD, BZ hazard then issue, BNZ, JMP, AND
        step(1, enc_i(7'h21, 12, 2, 0), 10, 0, 0, 0, 0, mk(10, 19, 0, 0, 0, 0, 0, 0, 1, 12, 1, 0, 2));
        step(1, enc_i(7'h20, 0, 12, 15'h7FFE), 11, 0, 0, 0, 0, bub(10, 1, 3));
        step(1, enc_i(7'h20, 0, 12, 15'h7FFE), 11, 0, 0, 0, 0,
             mk(11, 0, 32'hFFFF_FFFE, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3));
        step(1, enc_i(7'h24, 0, 1, 3), 12, 0, 0, 0, 0, mk(12, 5, 3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3));
        step(1, enc_i(7'h30, 0, 5, 15'h4000), 13, 0, 0, 0, 0,
             mk(13, 0, 32'hFFFF_C000, 0, 0, 0, 0, 2, 0, 0, 0, 0, 3));
        step(1, enc_r(7'h08, 13, 2, 1, 0), 14, 0, 0, 0, 0, mk(14, 19, 5, 8, 0, 0, 0, 0, 1, 13, 0, 0, 3));

        // mid-cycle asynchronous reset clears outputs at once
        @(posedge CLK);
        #3 reset = 1'b0;
        #1 check("reset_async", dut_now(STALL), bub(0, 0, 0));

        // 19-21: held in reset, first edge after release, undefined opcode
        step(0, enc_r(7'h02, 14, 1, 2, 0), 15, 0, 0, 0, 0, bub(0, 0, 0));
        step(1, enc_r(7'h02, 14, 1, 2, 0), 16, 0, 0, 0, 0, mk(16, 0, 0, 2, 0, 0, 0, 0, 1, 14, 0, 0, 0));
        step(1, enc_i(7'h7F, 1, 14, 1), 17, 0, 0, 0, 0, bub(16, 0, 0));

        @(negedge CLK);
        IR_1 = '0;
        repeat (3) @(posedge CLK);
        #2;
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
